// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths and the read-owner encoding used by
// mem_arbiter to route a memory read response back to the requesting port.
package mem_arbiter_pkg;

  localparam int AW = 16;  // word address width
  localparam int DW = 16;  // data width

  // Which port owns the read response arriving in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction / data) arbiter in front of a
// single-ported-per-direction memory with one-cycle read latency.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   i_req/i_addr          : instruction read request (held until i_ack)
//   i_ack/i_rdata/i_rvalid: grant strobe, read data, one-cycle data valid
//   d_req/d_we/d_addr/d_wdata : data port request (d_we=1 write)
//   d_ack/d_rdata/d_rvalid: as for the instruction port
//   m_raddr/m_re          : memory read command
//   m_waddr/m_wdata/m_we  : memory write command
//   m_rdata               : memory read data, valid the cycle after m_re
//
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration on
// contention; otherwise the data port has fixed priority.
//
// Grant, ack and memory commands are combinational from the requests. The
// owner of an outstanding read is registered at the grant edge and steers
// m_rdata to that port in the following cycle; rdata outputs hold the last
// delivered word between strobes.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  output logic          i_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic [AW-1:0] m_raddr,
  output logic          m_re,
  output logic [AW-1:0] m_waddr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  input  logic [DW-1:0] m_rdata
);

  owner_e        owner_q, owner_d;
  logic [DW-1:0] i_rdata_q, d_rdata_q;
  logic          gnt_i, gnt_d;

`ifdef MEM_ARBITER_RR_EN
  // 1: instruction port wins the next contended cycle.
  logic prio_i_q;
`endif

  // Arbitration; nothing is granted while reset is high.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!reset) begin
`ifdef MEM_ARBITER_RR_EN
      if (i_req && d_req) begin
        gnt_i = prio_i_q;
        gnt_d = !prio_i_q;
      end else begin
        gnt_i = i_req;
        gnt_d = d_req;
      end
`else
      gnt_d = d_req;
      gnt_i = i_req && !d_req;
`endif
    end
  end

  assign i_ack = gnt_i;
  assign d_ack = gnt_d;

  // Memory command
  always_comb begin
    m_re    = gnt_i || (gnt_d && !d_we);
    m_raddr = gnt_i ? i_addr : d_addr;
    m_we    = gnt_d && d_we;
    m_waddr = d_addr;
    m_wdata = d_wdata;
  end

  // Owner of the read response due next cycle; writes leave no owner.
  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_i)                owner_d = OWN_I;
    else if (gnt_d && !d_we)  owner_d = OWN_D;
  end

  // Strobes are masked by reset so a read granted just before reset
  // asserts never reports data.
  assign i_rvalid = (owner_q == OWN_I) && !reset;
  assign d_rvalid = (owner_q == OWN_D) && !reset;
  assign i_rdata  = i_rvalid ? m_rdata : i_rdata_q;
  assign d_rdata  = d_rvalid ? m_rdata : d_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= OWN_NONE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (i_rvalid) i_rdata_q <= m_rdata;
      if (d_rvalid) d_rdata_q <= m_rdata;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Pointer moves only when both ports competed; the loser goes first next.
  always_ff @(posedge clk) begin
    if (reset)                            prio_i_q <= 1'b1;
    else if (i_req && d_req)              prio_i_q <= !gnt_i;
  end
`endif

endmodule
